// File: rtl/relu_maxpool_l1.sv
// ReLU followed by 2x2 stride-2 max pooling on a raster-order conv stream.
// Row-pair partial maxima are kept in a half-width line buffer with asynchronous read.
module relu_maxpool_l1 #(
  parameter int IN_W = 26,
  parameter int IN_H = 26,
  parameter int DW   = 16
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pxl_in,
  input  logic          valid_in,
  output logic [DW-1:0] pool_out,
  output logic          pool_valid,
  output logic          frame_done
);
  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);
  localparam int LW = IN_W / 2;
  localparam int IW = (LW > 1) ? $clog2(LW) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] hold;
  logic [DW-1:0] r;
  logic [DW-1:0] lb_rd;
  logic [IW-1:0] idx;
  logic          col_last, row_last;
  logic [DW-1:0] linebuf [LW];

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign r        = pxl_in[DW-1] ? '0 : pxl_in;
  assign idx      = IW'(col >> 1);
  assign lb_rd    = linebuf[idx];
  assign col_last = (col == CW'(IN_W - 1));
  assign row_last = (row == RW'(IN_H - 1));

  // Even rows deposit the horizontal max of each column pair for the odd row to finish.
  always_ff @(posedge clk) begin
    if (valid_in && !reset && !row[0] && col[0])
      linebuf[idx] <= umax(hold, r);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      pool_out   <= '0;
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        case ({row[0], col[0]})
          2'b00: hold <= r;
          2'b10: hold <= umax(lb_rd, r);
          2'b11: begin
            pool_out   <= umax(hold, r);
            pool_valid <= 1'b1;
            frame_done <= row_last && col_last;
          end
          default: ;
        endcase
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_relu_maxpool_l1.sv
// Randomized scoreboard bench: a 4x4 and a 26x26 instance checked against a window-max model.
module tb_relu_maxpool_l1;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pxl_s, pxl_b, pool_out_s, pool_out_b;
  logic        valid_s, valid_b, pool_valid_s, pool_valid_b, frame_done_s, frame_done_b;
  logic        acc_s, acc_b, rs;

  typedef struct { logic [15:0] val; bit last; } exp_t;
  exp_t exp_s[$], exp_b[$];
  int checks = 0, errors = 0;
  int pv_cnt[2] = '{0, 0};
  int fd_cnt[2] = '{0, 0};
  logic [15:0] last_out[2];

  always #5 clk = ~clk;

  relu_maxpool_l1 #(.IN_W(4), .IN_H(4), .DW(16)) u_small (
    .clk(clk), .reset(reset), .pxl_in(pxl_s), .valid_in(valid_s),
    .pool_out(pool_out_s), .pool_valid(pool_valid_s), .frame_done(frame_done_s));

  relu_maxpool_l1 #(.IN_W(26), .IN_H(26), .DW(16)) u_big (
    .clk(clk), .reset(reset), .pxl_in(pxl_b), .valid_in(valid_b),
    .pool_out(pool_out_b), .pool_valid(pool_valid_b), .frame_done(frame_done_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] x);
    return ($signed(x) < 0) ? 16'h0 : x;
  endfunction

  // Reference: each pooled output is the largest ReLU'd pixel of its 2x2 window.
  task automatic model(input bit big, input logic [15:0] f[$], input int w, input int h);
    exp_t e;
    for (int wr = 0; wr < h / 2; wr++)
      for (int wc = 0; wc < w / 2; wc++) begin
        e.val = 16'h0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (relu(f[(2*wr+dr)*w + 2*wc+dc]) > e.val) e.val = relu(f[(2*wr+dr)*w + 2*wc+dc]);
        e.last = (wr == h/2 - 1) && (wc == w/2 - 1);
        if (big) exp_b.push_back(e); else exp_s.push_back(e);
      end
  endtask

  always @(posedge clk) begin
    acc_s <= valid_s & ~reset;
    acc_b <= valid_b & ~reset;
    rs    <= reset;
  end

  task automatic mon(input int b, input logic [15:0] po, input logic pv, input logic fd, input logic ac);
    exp_t e;
    if (rs) begin
      chk("reset_out", 32'(po), 32'h0);
      chk("reset_valid", 32'(pv), 32'h0);
      chk("reset_done", 32'(fd), 32'h0);
      last_out[b] = 16'h0;
    end else if (pv) begin
      pv_cnt[b]++;
      if (fd) fd_cnt[b]++;
      chk("valid_after_accept", 32'(ac), 32'h1);
      if ((b == 1) ? (exp_b.size() == 0) : (exp_s.size() == 0)) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse inst%0d: got value %0h expected no pulse at %0t", b, po, $time);
      end else begin
        e = (b == 1) ? exp_b.pop_front() : exp_s.pop_front();
        chk(b ? "pool_out_big" : "pool_out_small", 32'(po), 32'(e.val));
        chk(b ? "frame_done_big" : "frame_done_small", 32'(fd), 32'(e.last));
      end
      last_out[b] = po;
    end else begin
      chk("done_without_valid", 32'(fd), 32'h0);
      chk("hold_out", 32'(po), 32'(last_out[b]));
    end
  endtask

  always @(negedge clk) begin
    mon(0, pool_out_s, pool_valid_s, frame_done_s, acc_s);
    mon(1, pool_out_b, pool_valid_b, frame_done_b, acc_b);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put(input bit big, input logic [15:0] px);
    if (big) begin valid_b = 1'b1; pxl_b = px; end
    else begin valid_s = 1'b1; pxl_s = px; end
    @(posedge clk); #1;
    valid_s = 1'b0; valid_b = 1'b0;
    pxl_s = 16'($urandom); pxl_b = 16'($urandom);
  endtask

  // mode 0: continuous, 1: valid toggles plus a 5-cycle gap mid-row, 2: random gaps
  task automatic drive(input bit big, input logic [15:0] f[$], input int mode);
    for (int i = 0; i < f.size(); i++) begin
      put(big, f[i]);
      if (mode == 1) begin idle(1); if (i == 5) idle(5); end
      else if (mode == 2) idle($urandom_range(0, 2));
    end
  endtask

  logic [15:0] f[$];

  initial begin
    reset = 1'b1; valid_s = 1'b0; valid_b = 1'b0; pxl_s = 16'h0; pxl_b = 16'h0;
    last_out[0] = 16'h0; last_out[1] = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    f = {};
    for (int i = 1; i <= 16; i++) f.push_back(16'(i));
    model(0, f, 4, 4); drive(0, f, 0); idle(3);
    model(0, f, 4, 4); drive(0, f, 1); idle(3);

    // Aborted partial frame, then reset coinciding with a valid pixel that must be dropped.
    for (int i = 0; i < 5; i++) put(0, 16'h0100 + 16'(i));
    reset = 1'b1; valid_s = 1'b1; pxl_s = 16'h7777;
    @(posedge clk); #1;
    reset = 1'b0; valid_s = 1'b0;
    model(0, f, 4, 4); drive(0, f, 0); idle(3);

    for (int k = 0; k < 3; k++) begin
      f = {};
      for (int i = 0; i < 16; i++) f.push_back(16'($urandom));
      model(0, f, 4, 4); drive(0, f, 2);
    end
    idle(3);

    f = {};
    for (int i = 0; i < 676; i++) f.push_back(16'hFFF0);
    model(1, f, 26, 26); drive(1, f, 0); idle(3);

    f = {};
    for (int i = 0; i < 676; i++) f.push_back(16'($urandom));
    f[0] = 16'h0005; f[1] = 16'h8000; f[26] = 16'h7FFF; f[27] = 16'h0003;
    model(1, f, 26, 26); drive(1, f, 2);

    f = {};
    for (int i = 0; i < 676; i++) f.push_back(16'(i));
    model(1, f, 26, 26); drive(1, f, 0);
    f = {};
    for (int i = 0; i < 676; i++) f.push_back(16'(16'h4000 - i));
    model(1, f, 26, 26); drive(1, f, 0);

    for (int t = 0; t < 50 && (exp_s.size() != 0 || exp_b.size() != 0); t++) @(posedge clk);
    @(negedge clk);
    chk("small_queue_left", 32'(exp_s.size()), 32'h0);
    chk("big_queue_left", 32'(exp_b.size()), 32'h0);
    chk("small_pulses", 32'(pv_cnt[0]), 32'd24);
    chk("big_pulses", 32'(pv_cnt[1]), 32'd676);
    chk("small_frames", 32'(fd_cnt[0]), 32'd6);
    chk("big_frames", 32'(fd_cnt[1]), 32'd4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
